// File: rtl/riscv_wb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_wb_pkg : shared write-back widths, grant and arbiter-state encodings
// Rev 1.0
// ---------------------------------------------------------------------------
package riscv_wb_pkg;

  localparam int XLEN      = 64;
  localparam int REGADDR_W = 5;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_LONG = 2'd2
  } wb_grant_t;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    FORCE = 1'b1
  } wb_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_starve_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_starve_counter : saturating lost-arbitration counter with limit-hit flag
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_starve_counter
  import riscv_wb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [CNT_W:0] LIMIT_W = (CNT_W + 1)'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the loss that, if taken now, reaches the limit.
  assign hit_o = (({1'b0, cnt_q} + 1'b1) == LIMIT_W);

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_port_arbiter : register-file write-port arbiter, MEM/WB vs long unit
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_port_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REGADDR_W-1:0] wrd,
  input  logic [XLEN-1:0]      wr,
  input  logic [XLEN-1:0]      wd,
  input  logic                 wm2reg,
  input  logic                 wwreg,
  input  logic                 lvalid,
  input  logic [REGADDR_W-1:0] lrd,
  input  logic [XLEN-1:0]      lres,
  output logic                 lready,
  output logic                 wbstall,
  output logic                 rfwe,
  output logic [REGADDR_W-1:0] rfwa,
  output logic [XLEN-1:0]      rfwd
);

  wb_arb_state_t        state_q, state_d;
  wb_grant_t            grant;
  logic                 preq, lreq, lzero;
  logic                 cnt_inc, cnt_clr, cnt_hit;
  logic [XLEN-1:0]      pdata;

  logic                 rfwe_q, rfwe_d;
  logic [REGADDR_W-1:0] rfwa_q, rfwa_d;
  logic [XLEN-1:0]      rfwd_q, rfwd_d;

  assign preq  = wwreg && (wrd != '0);
  assign lreq  = lvalid && (lrd != '0);
  assign lzero = lvalid && (lrd == '0);
  assign pdata = wm2reg ? wd : wr;

  wb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk  (clk),
    .rst  (rst),
    .clr_i(cnt_clr),
    .inc_i(cnt_inc),
    .hit_o(cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = GNT_NONE;
    lready  = 1'b0;
    wbstall = 1'b0;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      ARB: begin
        if (preq) begin
          grant = GNT_PIPE;
          if (lreq) begin
            cnt_inc = 1'b1;
            if (cnt_hit) state_d = FORCE;
          end else if (!lzero) begin
            cnt_clr = 1'b1;
          end
        end else if (lreq) begin
          grant   = GNT_LONG;
          lready  = 1'b1;
          cnt_clr = 1'b1;
        end else if (!lzero) begin
          cnt_clr = 1'b1;
        end
      end
      FORCE: begin
        // Any exit from FORCE returns to ARB with a fresh wait count.
        state_d = ARB;
        cnt_clr = 1'b1;
        if (lreq) begin
          grant   = GNT_LONG;
          lready  = 1'b1;
          wbstall = preq;
        end
      end
      default: begin
        state_d = ARB;
        cnt_clr = 1'b1;
      end
    endcase
    if (lzero) lready = 1'b1;
    if (rst) begin
      lready  = 1'b0;
      wbstall = 1'b0;
    end
  end

  always_comb begin
    rfwe_d = (grant != GNT_NONE);
    rfwa_d = rfwa_q;
    rfwd_d = rfwd_q;
    unique case (grant)
      GNT_PIPE: begin
        rfwa_d = wrd;
        rfwd_d = pdata;
      end
      GNT_LONG: begin
        rfwa_d = lrd;
        rfwd_d = lres;
      end
      default: begin
        rfwa_d = rfwa_q;
        rfwd_d = rfwd_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rfwe_q <= 1'b0;
      rfwa_q <= '0;
      rfwd_q <= '0;
    end else begin
      rfwe_q <= rfwe_d;
      rfwa_q <= rfwa_d;
      rfwd_q <= rfwd_d;
    end
  end

  assign rfwe = rfwe_q;
  assign rfwa = rfwa_q;
  assign rfwd = rfwd_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter : directed + randomized bench with a loss-count model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wrd;
  logic [63:0] wr, wd;
  logic        wm2reg, wwreg;
  logic        lvalid;
  logic [4:0]  lrd;
  logic [63:0] lres;
  logic        lready, wbstall, rfwe;
  logic [4:0]  rfwa;
  logic [63:0] rfwd;

  int checks = 0;
  int errors = 0;

  // Reference model: losses since the long unit was last served.
  int          losses;
  logic        m_rfwe;
  logic [4:0]  m_rfwa;
  logic [63:0] m_rfwd;
  logic        l_done, last_stall;
  logic        obs_lready, obs_wbstall;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .wrd(wrd), .wr(wr), .wd(wd), .wm2reg(wm2reg),
    .wwreg(wwreg), .lvalid(lvalid), .lrd(lrd), .lres(lres), .lready(lready),
    .wbstall(wbstall), .rfwe(rfwe), .rfwa(rfwa), .rfwd(rfwd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already driven at negedge; check, clock, update model.
  task automatic cyc();
    logic preq, lreq, lzero, e_lready, e_wbstall;
    int   g, nxt;
    #1;
    preq  = wwreg && (wrd != 5'd0);
    lreq  = lvalid && (lrd != 5'd0);
    lzero = lvalid && (lrd == 5'd0);
    chkb("rfwe", rfwe, m_rfwe);
    chk("rfwa", 64'(rfwa), 64'(m_rfwa));
    chk("rfwd", rfwd, m_rfwd);
    g = 0; e_lready = 1'b0; e_wbstall = 1'b0; nxt = losses;
    if (!rst) begin
      if (lzero) e_lready = 1'b1;
      if (losses >= LIMIT) begin
        if (lreq) begin
          g = 2; e_lready = 1'b1; e_wbstall = preq;
        end
        nxt = 0;
      end else if (preq) begin
        g = 1;
        if (lreq) nxt = losses + 1;
        else if (!lzero) nxt = 0;
      end else if (lreq) begin
        g = 2; e_lready = 1'b1; nxt = 0;
      end else if (!lzero) begin
        nxt = 0;
      end
    end
    obs_lready  = lready;
    obs_wbstall = wbstall;
    chkb("lready", lready, e_lready);
    chkb("wbstall", wbstall, e_wbstall);
    @(posedge clk);
    if (rst) begin
      losses = 0; m_rfwe = 1'b0; m_rfwa = '0; m_rfwd = '0;
    end else begin
      losses = nxt;
      m_rfwe = (g != 0);
      if (g == 1) begin
        m_rfwa = wrd; m_rfwd = wm2reg ? wd : wr;
      end else if (g == 2) begin
        m_rfwa = lrd; m_rfwd = lres;
      end
    end
    l_done     = rst || (lvalid && e_lready);
    last_stall = e_wbstall && !rst;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wwreg = 1'b0; wrd = '0; wr = '0; wd = '0; wm2reg = 1'b0;
    lvalid = 1'b0; lrd = '0; lres = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    l_done = 1'b1; last_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    losses = 0; m_rfwe = 1'b0; m_rfwa = '0; m_rfwd = '0;
    cyc();
    chkb("reset_rfwe", rfwe, 1'b0);
    chk("reset_rfwd", rfwd, 64'd0);
    rst = 1'b0;

    // Pipeline only, both data sources.
    wwreg = 1'b1; wrd = 5'd5; wm2reg = 1'b0; wr = 64'h1234; wd = 64'hBEEF;
    cyc();
    chkb("pipe_rfwe", rfwe, 1'b1);
    chk("pipe_rfwa", 64'(rfwa), 64'd5);
    chk("pipe_rfwd_wr", rfwd, 64'h1234);
    wm2reg = 1'b1;
    cyc();
    chk("pipe_rfwd_wd", rfwd, 64'hBEEF);

    // x0 suppression on both sources.
    wrd = 5'd0;
    cyc();
    chkb("x0_pipe_rfwe", rfwe, 1'b0);
    chk("x0_pipe_hold", rfwd, 64'hBEEF);
    wwreg = 1'b0; lvalid = 1'b1; lrd = 5'd0; lres = 64'h55;
    cyc();
    chkb("x0_long_lready", obs_lready, 1'b1);
    chkb("x0_long_rfwe", rfwe, 1'b0);

    // Long only.
    lrd = 5'd7; lres = 64'hAA;
    cyc();
    chkb("long_lready", obs_lready, 1'b1);
    chk("long_rfwa", 64'(rfwa), 64'd7);
    chk("long_rfwd", rfwd, 64'hAA);
    lvalid = 1'b0;
    cyc();

    // Starvation: LIMIT losses, then forced grant with one-cycle stall.
    wwreg = 1'b1; wrd = 5'd3; wm2reg = 1'b0; lvalid = 1'b1; lrd = 5'd9; lres = 64'h99;
    for (int c = 0; c < LIMIT; c++) begin
      wr = 64'(c + 100);
      cyc();
      chkb("starve_lost_lready", obs_lready, 1'b0);
      chk("starve_pipe_rfwa", 64'(rfwa), 64'd3);
    end
    wr = 64'h777;
    cyc();
    chkb("force_lready", obs_lready, 1'b1);
    chkb("force_wbstall", obs_wbstall, 1'b1);
    chk("force_rfwa", 64'(rfwa), 64'd9);
    chk("force_rfwd", rfwd, 64'h99);
    lvalid = 1'b0;
    cyc();
    chkb("replay_wbstall", obs_wbstall, 1'b0);
    chk("replay_rfwa", 64'(rfwa), 64'd3);
    chk("replay_rfwd", rfwd, 64'h777);

    // Reset while forced with the long result pending.
    lvalid = 1'b1; lrd = 5'd11; lres = 64'h1111;
    for (int c = 0; c < LIMIT; c++) cyc();
    rst = 1'b1;
    cyc();
    chkb("rst_lready", obs_lready, 1'b0);
    chkb("rst_wbstall", obs_wbstall, 1'b0);
    chkb("rst_rfwe", rfwe, 1'b0);
    rst = 1'b0; lvalid = 1'b0; wwreg = 1'b0;
    cyc();
    lvalid = 1'b1; wwreg = 1'b1;
    for (int c = 0; c < LIMIT - 1; c++) begin
      cyc();
      chkb("post_rst_count_lready", obs_lready, 1'b0);
    end

    // Lost race for two cycles, then pipeline goes idle.
    wwreg = 1'b0; lvalid = 1'b0;
    cyc();
    wwreg = 1'b1; lvalid = 1'b1; lrd = 5'd12; lres = 64'hC0DE;
    cyc();
    cyc();
    wwreg = 1'b0;
    cyc();
    chkb("race_idle_lready", obs_lready, 1'b1);
    chkb("race_idle_wbstall", obs_wbstall, 1'b0);
    chk("race_idle_rfwa", 64'(rfwa), 64'd12);
    lvalid = 1'b0;

    // Randomized traffic obeying the handshake and stall-replay rules.
    l_done = 1'b1; last_stall = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!last_stall) begin
        wwreg  = ($urandom_range(0, 99) < 75);
        wrd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        wr     = {$urandom, $urandom};
        wd     = {$urandom, $urandom};
        wm2reg = 1'($urandom_range(0, 1));
      end
      if (!lvalid || l_done) begin
        lvalid = ($urandom_range(0, 99) < 55);
        lrd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        lres   = {$urandom, $urandom};
      end
      cyc();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the MEM/WB pipeline stage and the long-latency execution unit (mul/div), whose results complete out of band. It sits between the MEM/WB pipeline register outputs, the long-unit result handshake, and the register file. It drives the registered write port and asserts a stall to the hazard unit when the long unit is forced through. A bounded-wait counter guarantees the long unit cannot be starved by back-to-back pipeline writes.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive lost arbitrations (both requesting, pipeline granted) before the long unit is forced; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- wrd  in  5  MEM/WB destination register
- wr  in  64  MEM/WB execution result
- wd  in  64  MEM/WB data-memory output
- wm2reg  in  1  selects wd (1) or wr (0) as pipeline write data
- wwreg  in  1  pipeline register-write request
- lvalid  in  1  long-unit result valid; held with lrd/lres stable until lready
- lrd  in  5  long-unit destination register
- lres  in  64  long-unit result
- lready  out  1  long-unit result accepted this cycle (combinational)
- wbstall  out  1  freeze MEM/WB and upstream this cycle (combinational)
- rfwe  out  1  register-file write enable (registered)
- rfwa  out  5  register-file write address (registered)
- rfwd  out  64  register-file write data (registered)

## Operation
- preq = wwreg & (wrd != 0). lreq = lvalid & (lrd != 0).
- lvalid with lrd == 0: lready=1 in the same cycle, no port use, no wait-count change.
- Pipeline write data = wm2reg ? wd : wr.
- FSM states: ARB and FORCE. Wait counter cnt is 4 bits.
- ARB:
  - lreq only: grant long, lready=1, cnt to 0.
  - preq only: grant pipeline.
  - both: grant pipeline, lready=0, cnt+1. If cnt+1 == STARVE_LIMIT, go to FORCE.
  - neither: cnt to 0.
  - lvalid low: cnt to 0.
- FORCE:
  - lreq: grant long, lready=1, wbstall = preq, cnt to 0, go to ARB. The stalled pipeline write is presented again next cycle and wins, unless a new lreq arrives (normal ARB rules).
  - lvalid low (handshake violation): go to ARB, cnt to 0, no grant.
- In ARB, wbstall is always 0.
- Grant to NONE: rfwe=0 next cycle; rfwa and rfwd hold their previous values.
- WAW ordering between the pipeline and the long unit on the same register is excluded by issue logic. Writes occur in grant order.

## Timing
- Grant decision is combinational in cycle t. rfwe/rfwa/rfwd are updated at the end-of-t edge and are valid in t+1, for 1-cycle write latency.
- lready and wbstall are combinational in cycle t, from the current state, cnt, and inputs.
- Handshake: transfer occurs when lvalid & lready at a posedge. The long unit must not change lrd/lres while lvalid is high and lready is low.
- Reset (rst high at posedge): state ARB, cnt 0, rfwe 0, rfwa 0, rfwd 0.
- While rst is high, lready=0 and wbstall=0.
- Reset mid-handshake drops any pending long result. The long unit shares rst.
- Simultaneous preq in FORCE: the long unit wins and the pipeline is stalled exactly 1 cycle.
- Maximum long-unit wait: STARVE_LIMIT cycles of loss, then grant on the next cycle.

## Structure
- Shared package riscv_wb_pkg holds:
  - XLEN=64 and REGADDR_W=5
  - enum wb_grant_t {GNT_NONE, GNT_PIPE, GNT_LONG}
  - enum wb_arb_state_t {ARB, FORCE}
- One natural sub-module: wb_starve_counter, a saturating counter with clear and a limit-hit flag, parameterised by STARVE_LIMIT.
- The data mux and registered port stay in the top module.

## Test plan
- Pipeline only: wwreg=1, wrd=5, wm2reg=0, wr=0x1234 → next cycle rfwe=1, rfwa=5, rfwd=0x1234. Repeat with wm2reg=1, wd=0xBEEF → rfwd=0xBEEF.
- x0 suppression: wwreg=1, wrd=0 → rfwe=0. Then lvalid=1, lrd=0 → lready=1 same cycle, rfwe=0.
- Long only: lvalid=1, lrd=7, lres=0xAA → lready=1 same cycle, next cycle rfwe=1, rfwa=7, rfwd=0xAA.
- Starvation with STARVE_LIMIT=4: preq every cycle with lvalid=1 held, lrd=9:
  - Cycles 0-3: pipeline writes and lready=0.
  - Cycle 4: lready=1 and wbstall=1, with rfwa=9 written in cycle 5.
  - Cycle 5: the stalled pipeline write appears at the port in cycle 6.
- Reset mid-operation: assert rst in FORCE with lvalid high → next cycle state ARB, rfwe=0, lready=0 during reset, cnt=0 after release.
- Lost race then idle: both requesting for 2 cycles, then wwreg=0 → long granted on cycle 2 with wbstall=0, cnt cleared.
